ibuf_pwr_ctrl: RTL and testbench
================================

IBUF_PWR_CTRL -- requirements
Module: ibuf_pwr_ctrl

Interface
REQ-001 Parameter N, default 4: number of differential input lanes controlled (1..16).
REQ-002 Parameter WAKE, default 8: buffer settling time in clk cycles from IBUFDISABLE deassertion to ready (1..255).
REQ-003 Parameter IDLE, default 16: cycles a lane stays enabled after its last request drops (1..255).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 nreset  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is synchronized upstream.
REQ-006 req  input  N  per-lane request for a powered, settled input buffer.
REQ-007 force_on  input  1  global request applied to every lane (test or calibration use).
REQ-008 ibufdisable  output  N  per-lane drive to the buffer's IBUFDISABLE pin; 1 = buffer disabled.
REQ-009 ready  output  N  per-lane flag; 1 = buffer enabled and settled, data valid.
REQ-010 busy  output  1  1 when any lane is in WAIT or WAKE.

Function
REQ-011 Each lane SHALL run its own FSM with states OFF, WAIT, WAKE, ON and HOLD; every output SHALL be registered.
REQ-012 Lane request term: r[i] = req[i] OR force_on.
REQ-013 OFF: ibufdisable=1, ready=0; when r[i]=1, go to WAIT.
REQ-014 WAIT: ibufdisable=1, ready=0; if r[i]=0, return to OFF; if granted, go to WAKE.
REQ-015 The wake engine SHALL be shared: at most one lane SHALL be in WAKE at any time, which limits simultaneous bias-current inrush.
REQ-016 Grant rules: a grant issues only in a cycle with no lane in WAKE; candidates are lanes in WAIT with r=1; selection is round-robin starting at the lane after the last granted lane; the pointer is lane 0 after reset.
REQ-017 WAKE: ibufdisable=0, ready=0; the shared 8-bit counter counts WAKE cycles, then the lane goes to ON. A drop of r[i] during WAKE SHALL NOT abort the wake.
REQ-018 ON: ibufdisable=0, ready=1; if r[i]=0, go to HOLD and load the lane's idle counter with IDLE.
REQ-019 HOLD: ibufdisable=0, ready=1; if r[i]=1, return to ON; otherwise decrement the counter, and after IDLE cycles go to OFF.
REQ-020 Entering OFF from HOLD SHALL assert ibufdisable and deassert ready in the same cycle.
REQ-021 Latency: r[i] sampled high at edge k with an idle engine gives WAIT from k+1, ibufdisable[i]=0 from k+2, and ready[i]=1 from k+2+WAKE.
REQ-022 The engine frees in the cycle after its lane reaches ON; the next grant is made in that cycle, so consecutive wakes are WAKE+1 cycles apart.
REQ-023 Simultaneous requests on all lanes SHALL be served in round-robin order, with no lane skipped or starved.
REQ-024 A lane whose r drops in WAIT SHALL release its position; the round-robin pointer SHALL be unchanged.
REQ-025 busy SHALL be the registered OR of the per-lane WAIT and WAKE states.

Reset
REQ-026 nreset=0 SHALL immediately force all lanes to OFF, ibufdisable to all 1s, ready to 0, busy to 0, all counters to 0, and the pointer to 0, including mid-WAKE.
REQ-027 The first edge after deassertion SHALL evaluate requests normally; no spurious grant SHALL occur.

Verification
REQ-028 N=4, WAKE=8: req=0001 from edge 0 -> ibufdisable[0]=0 from edge 2, ready[0]=1 from edge 10, busy=0 from edge 11.
REQ-029 req=1111 at edge 0 -> lanes wake in order 0,1,2,3; ibufdisable falls at edges 2, 11, 20 and 29; only one lane is in WAKE at any time.
REQ-030 Lane 0 ON, req[0] drops at edge 50, IDLE=16 -> ready[0]=1 until edge 66; ibufdisable[0]=1 and ready[0]=0 from edge 67. A re-request at edge 60 returns the lane to ON with no wake.
REQ-031 req[2] pulses for 1 cycle while lane 1 is in WAKE -> lane 2 returns from WAIT to OFF and is never granted; lane 1 is unaffected.
REQ-032 nreset pulsed low during lane 3 WAKE -> ibufdisable=1111, ready=0000 and busy=0 asynchronously; with req held, the lane wakes again from lane 0's turn.
REQ-033 force_on=1 with req=0 -> all lanes reach ON; force_on=0 -> all lanes pass through HOLD and reach OFF after IDLE cycles.

Source files
------------

// File: rtl/ibuf_pwr_ctrl.sv
// Per-lane power sequencing for differential input buffers. A single shared
// wake engine settles one lane at a time; idle lanes drop back to disabled.
module ibuf_pwr_ctrl #(
  parameter int N    = 4,
  parameter int WAKE = 8,
  parameter int IDLE = 16
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] req,
  input  logic         force_on,
  output logic [N-1:0] ibufdisable,
  output logic [N-1:0] ready,
  output logic         busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] WAKE_LD = 8'(WAKE - 1);
  localparam logic [7:0] IDLE_LD = 8'(IDLE);

  typedef enum logic [2:0] {S_OFF, S_WAIT, S_WAKE, S_ON, S_HOLD} state_t;

  state_t        state_r  [N];
  state_t        state_s  [N];
  logic [7:0]    idle_r   [N];
  logic [7:0]    idle_s   [N];
  logic [7:0]    wake_cnt_r;
  logic [7:0]    wake_cnt_s;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] idx_s;
  logic [PW-1:0] gnt_idx_s;
  logic          gnt_any_s;
  logic          wake_busy_s;
  logic [N-1:0]  req_s;
  logic [N-1:0]  dis_s;
  logic [N-1:0]  rdy_s;
  logic [N-1:0]  act_s;
  logic [N-1:0]  act_r;
  logic [N-1:0]  ibufdisable_r;
  logic [N-1:0]  ready_r;
  logic          busy_r;

  // Round-robin grant of the shared wake engine, only while no lane is waking
  always_comb begin
    req_s       = req | {N{force_on}};
    wake_busy_s = 1'b0;
    gnt_any_s   = 1'b0;
    gnt_idx_s   = '0;
    idx_s       = '0;
    for (int i = 0; i < N; i++) begin
      wake_busy_s = wake_busy_s | (state_r[i] == S_WAKE);
    end
    for (int j = 0; j < N; j++) begin
      idx_s = PW'((int'(ptr_r) + j) % N);
      if (!wake_busy_s && !gnt_any_s && (state_r[idx_s] == S_WAIT) && req_s[idx_s]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = idx_s;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Per-lane next state, idle counters and the shared wake counter
  always_comb begin
    if (gnt_any_s) begin
      wake_cnt_s = WAKE_LD;
    end else if (wake_busy_s && (wake_cnt_r != 8'd0)) begin
      wake_cnt_s = wake_cnt_r - 8'd1;
    end else begin
      wake_cnt_s = wake_cnt_r;
    end
    for (int i = 0; i < N; i++) begin
      state_s[i] = state_r[i];
      idle_s[i]  = idle_r[i];
      case (state_r[i])
        S_OFF: begin
          if (req_s[i]) state_s[i] = S_WAIT;
          else          state_s[i] = S_OFF;
        end
        S_WAIT: begin
          if (!req_s[i])                                  state_s[i] = S_OFF;
          else if (gnt_any_s && (gnt_idx_s == PW'(i)))    state_s[i] = S_WAKE;
          else                                            state_s[i] = S_WAIT;
        end
        // A dropped request does not abort a wake already in progress
        S_WAKE: begin
          if (wake_cnt_r == 8'd0) state_s[i] = S_ON;
          else                    state_s[i] = S_WAKE;
        end
        S_ON: begin
          if (!req_s[i]) begin
            state_s[i] = S_HOLD;
            idle_s[i]  = IDLE_LD;
          end else begin
            state_s[i] = S_ON;
          end
        end
        S_HOLD: begin
          if (req_s[i]) begin
            state_s[i] = S_ON;
            idle_s[i]  = 8'd0;
          end else if (idle_r[i] <= 8'd1) begin
            state_s[i] = S_OFF;
            idle_s[i]  = 8'd0;
          end else begin
            state_s[i] = S_HOLD;
            idle_s[i]  = idle_r[i] - 8'd1;
          end
        end
        default: begin
          state_s[i] = S_OFF;
          idle_s[i]  = 8'd0;
        end
      endcase
    end
  end

  // Output decode from the current lane states, registered below
  always_comb begin
    dis_s = '0;
    rdy_s = '0;
    act_s = '0;
    for (int i = 0; i < N; i++) begin
      dis_s[i] = (state_r[i] == S_OFF)  || (state_r[i] == S_WAIT);
      rdy_s[i] = (state_r[i] == S_ON)   || (state_r[i] == S_HOLD);
      act_s[i] = (state_r[i] == S_WAIT) || (state_r[i] == S_WAKE);
    end
  end

  // State, counters, pointer and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N; i++) begin
        state_r[i] <= S_OFF;
        idle_r[i]  <= 8'd0;
      end
      wake_cnt_r    <= 8'd0;
      ptr_r         <= '0;
      act_r         <= '0;
      ibufdisable_r <= '1;
      ready_r       <= '0;
      busy_r        <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_r[i] <= state_s[i];
        idle_r[i]  <= idle_s[i];
      end
      wake_cnt_r <= wake_cnt_s;
      if (gnt_any_s) begin
        ptr_r <= (gnt_idx_s == PW'(N - 1)) ? '0 : gnt_idx_s + PW'(1);
      end else begin
        ptr_r <= ptr_r;
      end
      act_r         <= act_s;
      ibufdisable_r <= dis_s;
      ready_r       <= rdy_s;
      busy_r        <= |act_r;
    end
  end

  assign ibufdisable = ibufdisable_r;
  assign ready       = ready_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ibuf_pwr_ctrl.sv
// Directed bench for ibuf_pwr_ctrl (N=4, WAKE=8, IDLE=16); edge numbers count
// rising edges from the first one that samples the new stimulus (edge 0).
module tb_ibuf_pwr_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] req;
  logic       force_on;
  logic [3:0] ibufdisable;
  logic [3:0] ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ec     = -1;

  ibuf_pwr_ctrl #(.N(4), .WAKE(8), .IDLE(16)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req         (req),
    .force_on    (force_on),
    .ibufdisable (ibufdisable),
    .ready       (ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, ec, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic wait_to(input int e);
    while (ec < e) tick();
  endtask

  task automatic do_reset(input logic [3:0] r, input logic f);
    nreset   = 1'b0;
    req      = r;
    force_on = f;
    tick();
    tick();
    nreset = 1'b1;
    ec     = -1;
  endtask

  initial begin
    nreset   = 1'b0;
    req      = 4'b0000;
    force_on = 1'b0;
    tick();
    tick();
    chk("rst_dis",  ibufdisable, 4'b1111);
    chk("rst_rdy",  ready,       4'b0000);
    chk("rst_busy", {3'b000, busy}, 4'b0000);

    // Single lane wake latency, then idle hold and re-request
    do_reset(4'b0001, 1'b0);
    wait_to(1);  chk("l0_dis_e1",  ibufdisable, 4'b1111);
    wait_to(2);  chk("l0_dis_e2",  ibufdisable, 4'b1110);
                 chk("l0_busy_e2", {3'b000, busy}, 4'b0001);
    wait_to(9);  chk("l0_rdy_e9",  ready, 4'b0000);
    wait_to(10); chk("l0_rdy_e10", ready, 4'b0001);
                 chk("l0_busy_e10", {3'b000, busy}, 4'b0001);
    wait_to(11); chk("l0_busy_e11", {3'b000, busy}, 4'b0000);
    wait_to(49); req = 4'b0000;
    wait_to(66); chk("hold_rdy_e66", ready, 4'b0001);
                 chk("hold_dis_e66", ibufdisable, 4'b1110);
    wait_to(67); chk("off_rdy_e67", ready, 4'b0000);
                 chk("off_dis_e67", ibufdisable, 4'b1111);
    req = 4'b0001;
    wait_to(79); chk("rewake_rdy", ready, 4'b0001);
    req = 4'b0000;
    wait_to(89); chk("hold2_rdy", ready, 4'b0001);
    req = 4'b0001;
    wait_to(91); chk("rereq_busy", {3'b000, busy}, 4'b0000);
    wait_to(100); chk("rereq_rdy", ready, 4'b0001);
                  chk("rereq_dis", ibufdisable, 4'b1110);

    // All lanes at once: round-robin order, one wake at a time
    do_reset(4'b1111, 1'b0);
    for (int e = 0; e <= 38; e++) begin
      int nwake;
      wait_to(e);
      nwake = 0;
      for (int i = 0; i < 4; i++) nwake += (!ibufdisable[i] && !ready[i]) ? 1 : 0;
      chk("one_wake", {3'b000, (nwake <= 1)}, 4'b0001);
      if (e == 2)  chk("rr_dis_e2",  ibufdisable, 4'b1110);
      if (e == 10) chk("rr_dis_e10", ibufdisable, 4'b1110);
      if (e == 11) chk("rr_dis_e11", ibufdisable, 4'b1100);
      if (e == 19) chk("rr_dis_e19", ibufdisable, 4'b1100);
      if (e == 20) chk("rr_dis_e20", ibufdisable, 4'b1000);
      if (e == 29) chk("rr_dis_e29", ibufdisable, 4'b0000);
      if (e == 36) chk("rr_rdy_e36", ready, 4'b0111);
      if (e == 37) chk("rr_rdy_e37", ready, 4'b1111);
      if (e == 37) chk("rr_busy_e37", {3'b000, busy}, 4'b0001);
      if (e == 38) chk("rr_busy_e38", {3'b000, busy}, 4'b0000);
    end

    // Short pulse on lane 2 during lane 1 wake; pointer must stay put
    do_reset(4'b0010, 1'b0);
    wait_to(2);  chk("p_dis_e2", ibufdisable, 4'b1101);
    req = 4'b0110;
    wait_to(3);  req = 4'b0010;
    wait_to(5);  chk("p_dis_e5", ibufdisable, 4'b1101);
    wait_to(10); chk("p_rdy_e10", ready, 4'b0010);
    wait_to(12); chk("p_busy_e12", {3'b000, busy}, 4'b0000);
    wait_to(20); chk("p_dis_e20", ibufdisable, 4'b1101);
    req = 4'b0111;
    wait_to(23); chk("ptr_dis_e23", ibufdisable, 4'b1001);
    wait_to(31); chk("ptr_dis_e31", ibufdisable, 4'b1001);
    wait_to(32); chk("ptr_dis_e32", ibufdisable, 4'b1000);

    // Asynchronous reset in the middle of lane 3 wake
    do_reset(4'b1111, 1'b0);
    wait_to(30); chk("mr_dis_e30", ibufdisable, 4'b0000);
    #2 nreset = 1'b0;
    #1;
    chk("mr_dis_async",  ibufdisable, 4'b1111);
    chk("mr_rdy_async",  ready,       4'b0000);
    chk("mr_busy_async", {3'b000, busy}, 4'b0000);
    tick();
    nreset = 1'b1;
    ec     = -1;
    wait_to(1);  chk("mr_dis_e1",  ibufdisable, 4'b1111);
    wait_to(2);  chk("mr_dis_e2",  ibufdisable, 4'b1110);
    wait_to(11); chk("mr_dis_e11", ibufdisable, 4'b1100);

    // Global force_on, then release through HOLD to OFF
    do_reset(4'b0000, 1'b1);
    wait_to(37); chk("f_rdy_e37", ready, 4'b1111);
    wait_to(39); force_on = 1'b0;
    wait_to(41); chk("f_rdy_e41", ready, 4'b1111);
                 chk("f_dis_e41", ibufdisable, 4'b0000);
    wait_to(56); chk("f_rdy_e56", ready, 4'b1111);
    wait_to(57); chk("f_rdy_e57", ready, 4'b0000);
                 chk("f_dis_e57", ibufdisable, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
